// File: rtl/icache_2way.sv
// rtl/icache_2way.sv - two-way set-associative instruction cache with BurstRAM line fill
module icache_2way #(
    parameter int ADDRESS_BITWIDTH         = 32,
    parameter int DATA_BITWIDTH            = 32,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int SET_IX_BITWIDTH          = 1,
    parameter int RAM_BURST_DATA_COUNT     = 4,
    parameter int RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int RAM_DEPTH_BITWIDTH       = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 flush,
    input  logic [ADDRESS_BITWIDTH-1:0]          address,
    output logic [DATA_BITWIDTH-1:0]             data,
    output logic                                 data_ready,
    output logic                                 busy,
    output logic [31:0]                          stat_hits,
    output logic [31:0]                          stat_misses,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);
    localparam int WIX        = DATA_IX_IN_LINE_BITWIDTH;
    localparam int SIX        = SET_IX_BITWIDTH;
    localparam int WORDS      = 1 << WIX;
    localparam int SETS       = 1 << SIX;
    localparam int LINE_OFF   = WIX + 2;
    localparam int TAG_BW     = ADDRESS_BITWIDTH - SIX - LINE_OFF;
    localparam int WPB        = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int WPB_SHIFT  = $clog2(WPB);
    localparam int BEAT_SHIFT = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
    localparam int BCW        = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RECV_DATA} state_t;

    state_t                 state;
    logic [WIX-1:0]         a_word, req_word;
    logic [SIX-1:0]         a_set, req_set;
    logic [TAG_BW-1:0]      a_tag, req_tag;
    logic [1:0]             unused_addr;
    logic                   victim, victim_next;
    logic [BCW-1:0]         beat_cnt, crit_beat;
    logic                   flush_pend;
    logic [SETS-1:0]        valid [2];
    logic [SETS-1:0]        lru;
    logic [TAG_BW-1:0]      tags [2][SETS];
    logic [DATA_BITWIDTH-1:0] mem [2][SETS][WORDS];
    logic                   hit0, hit1, hit_way;
    logic [DATA_BITWIDTH-1:0] hit_word, crit_word;
    logic                   fill_beat, last_beat;
    logic [ADDRESS_BITWIDTH-1:0] line_addr;
    logic [RAM_DEPTH_BITWIDTH-1:0] br_addr_next;

    assign a_word      = address[LINE_OFF-1:2];
    assign a_set       = address[LINE_OFF+SIX-1:LINE_OFF];
    assign a_tag       = address[ADDRESS_BITWIDTH-1:LINE_OFF+SIX];
    assign unused_addr = address[1:0];

    assign hit0     = valid[0][a_set] && (tags[0][a_set] == a_tag);
    assign hit1     = valid[1][a_set] && (tags[1][a_set] == a_tag);
    assign hit_way  = ~hit0;
    assign hit_word = mem[hit_way][a_set][a_word];

    // Prefer an empty way before displacing the least recently used one
    assign victim_next = !valid[0][a_set] ? 1'b0 :
                         !valid[1][a_set] ? 1'b1 : lru[a_set];

    assign fill_beat = br_rd_data_valid && (state == WAIT_DATA || state == RECV_DATA);
    assign last_beat = fill_beat && (beat_cnt == LAST_BEAT);
    assign crit_beat = BCW'(req_word >> WPB_SHIFT);

    assign line_addr    = {req_tag, req_set, {LINE_OFF{1'b0}}};
    assign br_addr_next = RAM_DEPTH_BITWIDTH'(line_addr >> BEAT_SHIFT);

    assign br_cmd       = 1'b0;
    assign br_wr_data   = '0;
    assign br_data_mask = '0;

    always_comb begin
        crit_word = br_rd_data[DATA_BITWIDTH-1:0];
        for (int k = 0; k < WPB; k++) begin
            if ((int'(req_word) % WPB) == k)
                crit_word = br_rd_data[k*DATA_BITWIDTH +: DATA_BITWIDTH];
        end
    end

    // Line storage carries no reset; validity alone decides whether it is used
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            for (int k = 0; k < WPB; k++)
                mem[victim][req_set][WIX'(int'(beat_cnt) * WPB + k)] <=
                    br_rd_data[k*DATA_BITWIDTH +: DATA_BITWIDTH];
            if (last_beat)
                tags[victim][req_set] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            data_ready  <= 1'b0;
            data        <= '0;
            br_cmd_en   <= 1'b0;
            br_addr     <= '0;
            valid[0]    <= '0;
            valid[1]    <= '0;
            lru         <= '0;
            stat_hits   <= '0;
            stat_misses <= '0;
            req_word    <= '0;
            req_set     <= '0;
            req_tag     <= '0;
            victim      <= 1'b0;
            beat_cnt    <= '0;
            flush_pend  <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            br_cmd_en  <= 1'b0;
            if (state != IDLE && flush)
                flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid[0] <= '0;
                        valid[1] <= '0;
                        lru      <= '0;
                    end else if (enable) begin
                        if (hit0 || hit1) begin
                            data       <= hit_word;
                            data_ready <= 1'b1;
                            lru[a_set] <= hit0;
                            stat_hits  <= stat_hits + 32'd1;
                        end else begin
                            busy        <= 1'b1;
                            stat_misses <= stat_misses + 32'd1;
                            req_word    <= a_word;
                            req_set     <= a_set;
                            req_tag     <= a_tag;
                            victim      <= victim_next;
                            beat_cnt    <= '0;
                            flush_pend  <= 1'b0;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!br_busy) begin
                        br_cmd_en <= 1'b1;
                        br_addr   <= br_addr_next;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA, RECV_DATA: begin
                    if (fill_beat) begin
                        if (beat_cnt == crit_beat) begin
                            data       <= crit_word;
                            data_ready <= 1'b1;
                        end
                        beat_cnt <= beat_cnt + BCW'(1);
                        state    <= RECV_DATA;
                        if (last_beat) begin
                            valid[victim][req_set] <= 1'b1;
                            lru[req_set]           <= ~victim;
                            busy                   <= 1'b0;
                            state                  <= IDLE;
                            // A flush seen during the fill wipes everything, the new line included
                            if (flush_pend || flush) begin
                                valid[0] <= '0;
                                valid[1] <= '0;
                                lru      <= '0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_2way.sv
// tb/tb_icache_2way.sv - directed vector bench for icache_2way
module tb_icache_2way;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable, flush;
    logic [31:0] address;
    logic [31:0] data;
    logic        data_ready, busy;
    logic [31:0] stat_hits, stat_misses;
    logic        br_cmd, br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid, br_busy;

    int checks = 0;
    int errors = 0;
    int cmd_seen = 0;

    icache_2way dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .address(address),
        .data(data), .data_ready(data_ready), .busy(busy),
        .stat_hits(stat_hits), .stat_misses(stat_misses),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        int          hold;
        int          flush_beat;
        int          hits;
        int          misses;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h5000_0000 + a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (br_cmd_en) cmd_seen++;
    endtask

    task automatic fetch(input logic [31:0] a, input bit exp_hit, input int hold,
                         input int flush_beat, input int exp_hits, input int exp_misses);
        logic [31:0] line;
        int crit;
        int start;
        int waited;
        line    = a & 32'hFFFF_FFE0;
        crit    = int'(a[4:3]);
        start   = cmd_seen;
        address = a;
        enable  = 1'b1;
        br_busy = (hold > 0);
        step();
        if (exp_hit) begin
            enable = 1'b0;
            chk("hit_ready", 32'(data_ready), 32'd1);
            chk("hit_data", data, word_of(a));
            chk("hit_busy", 32'(busy), 32'd0);
            chk("hit_no_cmd", 32'(cmd_seen - start), 32'd0);
        end else begin
            // enable stays high on another address; the fill must ignore it
            address = 32'hFFFF_FFC0;
            chk("miss_busy", 32'(busy), 32'd1);
            chk("miss_ready", 32'(data_ready), 32'd0);
            for (int i = 0; i < hold; i++) step();
            chk("cmd_held", 32'(cmd_seen - start), 32'd0);
            br_busy = 1'b0;
            waited = 0;
            while (!br_cmd_en && waited < 10) begin
                step();
                waited++;
            end
            chk("cmd_en", 32'(br_cmd_en), 32'd1);
            chk("br_addr", 32'(br_addr), (line >> 3) & 32'hF);
            for (int b = 0; b < 4; b++) begin
                br_rd_data       = {word_of(line + 32'(8*b + 4)), word_of(line + 32'(8*b))};
                br_rd_data_valid = 1'b1;
                flush            = (b == flush_beat);
                if (b == 3) enable = 1'b0;
                step();
                br_rd_data_valid = 1'b0;
                flush            = 1'b0;
                if (b == crit) begin
                    chk("crit_ready", 32'(data_ready), 32'd1);
                    chk("crit_data", data, word_of(a));
                end else begin
                    chk("beat_ready", 32'(data_ready), 32'd0);
                end
                chk("fill_busy", 32'(busy), (b == 3) ? 32'd0 : 32'd1);
            end
            chk("cmd_pulses", 32'(cmd_seen - start), 32'd1);
        end
        chk("stat_hits", stat_hits, 32'(exp_hits));
        chk("stat_misses", stat_misses, 32'(exp_misses));
        step();
        chk("ready_drop", 32'(data_ready), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h00, 1'b0, 0, -1, 0, 1};
        vecs[1]  = '{32'h1C, 1'b1, 0, -1, 1, 1};
        vecs[2]  = '{32'h40, 1'b0, 0, -1, 1, 2};
        vecs[3]  = '{32'h80, 1'b0, 0, -1, 1, 3};
        vecs[4]  = '{32'h44, 1'b1, 0, -1, 2, 3};
        vecs[5]  = '{32'h00, 1'b0, 0, -1, 2, 4};
        vecs[6]  = '{32'h34, 1'b0, 5, -1, 2, 5};
        vecs[7]  = '{32'h3C, 1'b1, 0, -1, 3, 5};
        vecs[8]  = '{32'h60, 1'b0, 0,  2, 3, 6};
        vecs[9]  = '{32'h60, 1'b0, 0, -1, 3, 7};
        vecs[10] = '{32'h34, 1'b0, 0, -1, 3, 8};
        vecs[11] = '{32'h64, 1'b1, 0, -1, 4, 8};

        rst = 1'b0;
        enable = 1'b0;
        flush = 1'b0;
        address = '0;
        br_rd_data = '0;
        br_rd_data_valid = 1'b0;
        br_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_cmd_en", 32'(br_cmd_en), 32'd0);
        chk("rst_cmd", 32'(br_cmd), 32'd0);
        chk("rst_br_addr", 32'(br_addr), 32'd0);
        chk("rst_hits", stat_hits, 32'd0);
        chk("rst_misses", stat_misses, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++)
            fetch(vecs[i].addr, vecs[i].hit, vecs[i].hold, vecs[i].flush_beat,
                  vecs[i].hits, vecs[i].misses);

        // flush in IDLE swallows a simultaneous fetch
        address = 32'h64;
        enable  = 1'b1;
        flush   = 1'b1;
        step();
        enable = 1'b0;
        flush  = 1'b0;
        chk("flush_en_ready", 32'(data_ready), 32'd0);
        chk("flush_en_busy", 32'(busy), 32'd0);
        chk("flush_en_hits", stat_hits, 32'd4);
        chk("flush_en_misses", stat_misses, 32'd8);
        fetch(32'h64, 1'b0, 0, -1, 4, 9);

        // stray beat while idle
        br_rd_data       = 64'hDEAD_BEEF_0BAD_F00D;
        br_rd_data_valid = 1'b1;
        step();
        br_rd_data_valid = 1'b0;
        chk("stray_ready", 32'(data_ready), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        fetch(32'h64, 1'b1, 0, -1, 5, 9);

        // reset during beat 1
        address = 32'h120;
        enable  = 1'b1;
        br_busy = 1'b0;
        step();
        enable = 1'b0;
        step();
        chk("rst_mid_cmd", 32'(br_cmd_en), 32'd1);
        br_rd_data       = {word_of(32'h124), word_of(32'h120)};
        br_rd_data_valid = 1'b1;
        step();
        chk("rst_mid_pre_ready", 32'(data_ready), 32'd1);
        br_rd_data = {word_of(32'h12C), word_of(32'h128)};
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(data_ready), 32'd0);
        chk("rst_mid_data", data, 32'd0);
        chk("rst_mid_br_addr", 32'(br_addr), 32'd0);
        chk("rst_mid_hits", stat_hits, 32'd0);
        chk("rst_mid_misses", stat_misses, 32'd0);
        br_rd_data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        fetch(32'h120, 1'b0, 0, -1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
